sample_strobe_gen: RTL

//   Downstream consumer of the UART-configured sample clock divisor. Turns the 16-bit divisor

---
 rtl/sample_strobe_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sample_strobe_gen.sv
// rtl/sample_strobe_gen.sv - periodic one-cycle sample strobe from a UART-configured divisor
// Optional adc_clk output (half-period high time) enabled by defining SAMPLE_CLK_OUT_EN.
module sample_strobe_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cfg_done,
  input  logic             enable,
  output logic             sample_en,
  output logic             running,
  output logic [DIV_W-1:0] div_active,
  output logic [CNT_W-1:0] sample_cnt
`ifdef SAMPLE_CLK_OUT_EN
  ,
  output logic             adc_clk
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } state_t;

  localparam logic [DIV_W-1:0] ONE_D   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SAT_CNT = {CNT_W{1'b1}};

  state_t           state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] pend_div, pend_div_d;
  logic             pending, pending_d;
  logic             cfg_done_q;
  logic             load;
  logic [DIV_W-1:0] div_active_d;
  logic [CNT_W-1:0] sample_cnt_d;
  logic             sample_en_d;
  logic [DIV_W-1:0] reload_div;

  assign load       = cfg_done & ~cfg_done_q;
  assign running    = (state == ST_RUN);
  // A pending update takes effect exactly at the boundary that reloads the counter.
  assign reload_div = pending ? pend_div : div_active;

`ifdef SAMPLE_CLK_OUT_EN
  logic [DIV_W-1:0] hcnt, hcnt_d;
  logic             adc_clk_d;
  logic [DIV_W-1:0] high_time;

  // (d+1)>>1 without widening: d>>1 plus the low bit.
  assign high_time = (reload_div >> 1) + {{(DIV_W-1){1'b0}}, reload_div[0]};
`endif

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    pend_div_d   = pend_div;
    pending_d    = pending;
    div_active_d = div_active;
    sample_cnt_d = sample_cnt;
    sample_en_d  = 1'b0;
`ifdef SAMPLE_CLK_OUT_EN
    hcnt_d       = '0;
    adc_clk_d    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (pending) begin
          div_active_d = pend_div;
          pending_d    = 1'b0;
        end
        if (enable) begin
          state_d      = ST_RUN;
          sample_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == '0) begin
          sample_en_d  = 1'b1;
          if (sample_cnt != SAT_CNT) sample_cnt_d = sample_cnt + ONE_C;
          cnt_d        = reload_div;
          div_active_d = reload_div;
          pending_d    = 1'b0;
`ifdef SAMPLE_CLK_OUT_EN
          adc_clk_d    = 1'b1;
          hcnt_d       = (high_time == '0) ? '0 : high_time - ONE_D;
`endif
        end else begin
          cnt_d = cnt - ONE_D;
`ifdef SAMPLE_CLK_OUT_EN
          if (hcnt != '0) begin
            adc_clk_d = 1'b1;
            hcnt_d    = hcnt - ONE_D;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Loaded after the apply above so a same-cycle load waits for the next boundary.
    if (load) begin
      pend_div_d = clk_div;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pend_div   <= '0;
      pending    <= 1'b0;
      cfg_done_q <= 1'b0;
      div_active <= '0;
      sample_cnt <= '0;
      sample_en  <= 1'b0;
`ifdef SAMPLE_CLK_OUT_EN
      hcnt       <= '0;
      adc_clk    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pend_div   <= pend_div_d;
      pending    <= pending_d;
      cfg_done_q <= cfg_done;
      div_active <= div_active_d;
      sample_cnt <= sample_cnt_d;
      sample_en  <= sample_en_d;
`ifdef SAMPLE_CLK_OUT_EN
      hcnt       <= hcnt_d;
      adc_clk    <= adc_clk_d;
`endif
    end
  end

endmodule
